// File: rtl/counter_display_scheduler.sv
// counter_display_scheduler: prescaled count strobe, counter clear
// and up/down select sequencing for the 7-segment counter path.
module counter_display_scheduler #(
  parameter int PRESCALE   = 50_000_000,
  parameter int AUTO_WRAPS = 2
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       start,
  input  logic       stop,
  input  logic       dir_req,
  input  logic       auto_mode,
  output logic       cnt_en,
  output logic       cnt_clr,
  output logic       select,
  output logic       busy,
  output logic [1:0] state
);

  localparam int PW = $clog2(PRESCALE);
  localparam int WW = $clog2(AUTO_WRAPS + 1);
  localparam logic [PW-1:0] PRE_MAX  = PW'(PRESCALE - 1);
  localparam logic [WW-1:0] WRAP_MAX = WW'(AUTO_WRAPS);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    PAUSE  = 2'b10,
    SWITCH = 2'b11
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [3:0]    step_q, step_d;
  logic [WW-1:0] wrap_q, wrap_d;
  logic          sel_q, sel_d;
  logic          en_q, en_d;
  logic          clr_q, clr_d;
  logic          busy_q, busy_d;
  logic [PW-1:0] pre_inc;

  assign pre_inc = (pre_q == PRE_MAX) ? '0 : pre_q + PW'(1);

  // Next-state: mode transitions, then the strobe that lands on the
  // cycle whose prescaler value is the last one of a period.
  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    step_d  = step_q;
    wrap_d  = auto_mode ? wrap_q : '0;
    sel_d   = sel_q;
    clr_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          pre_d   = '0;
          step_d  = '0;
          wrap_d  = '0;
          clr_d   = 1'b1;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = PAUSE;
        end else if (dir_req) begin
          sel_d  = ~sel_q;
          step_d = '0;
          wrap_d = '0;
          pre_d  = '0;
        end else if (auto_mode && wrap_q >= WRAP_MAX) begin
          state_d = SWITCH;
          sel_d   = ~sel_q;
          wrap_d  = '0;
          pre_d   = '0;
        end else begin
          pre_d = pre_inc;
        end
      end
      PAUSE: begin
        if (start) begin
          state_d = RUN;
        end else if (dir_req) begin
          sel_d  = ~sel_q;
          step_d = '0;
          wrap_d = '0;
          pre_d  = '0;
        end
      end
      SWITCH: begin
        wrap_d  = '0;
        pre_d   = '0;
        state_d = stop ? PAUSE : RUN;
      end
      default: state_d = IDLE;
    endcase
    en_d = (state_d == RUN) && (pre_d == PRE_MAX);
    if (en_d) begin
      step_d = step_q + 4'd1;
      if (auto_mode && step_q == 4'hF && wrap_q < WRAP_MAX)
        wrap_d = wrap_q + WW'(1);
    end
    busy_d = (state_d == RUN) || (state_d == SWITCH);
  end

  // State and registered outputs, synchronous clear.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      pre_q   <= '0;
      step_q  <= '0;
      wrap_q  <= '0;
      sel_q   <= 1'b0;
      en_q    <= 1'b0;
      clr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      step_q  <= step_d;
      wrap_q  <= wrap_d;
      sel_q   <= sel_d;
      en_q    <= en_d;
      clr_q   <= clr_d;
      busy_q  <= busy_d;
    end
  end

  assign cnt_en  = en_q;
  assign cnt_clr = clr_q;
  assign select  = sel_q;
  assign busy    = busy_q;
  assign state   = state_q;

endmodule
